// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing one alu_mirisc_v (3-cycle accept/exec/respond).
// Define ALU_ARB_OPCHECK_EN to flag illegal op codes with rsp_err_o and zero the result.

module alu_mirisc_v (
  input  logic [5:0]  operator_i,
  input  logic [31:0] operand_a_i,
  input  logic [31:0] operand_b_i,
  output logic [31:0] result_o,
  output logic        comparison_result_o
);
  localparam logic [5:0] OpAdd = 6'b011000;
  localparam logic [5:0] OpSub = 6'b011001;
  localparam logic [5:0] OpXor = 6'b101111;
  localparam logic [5:0] OpOr  = 6'b101110;
  localparam logic [5:0] OpAnd = 6'b010101;
  localparam logic [5:0] OpSra = 6'b100100;
  localparam logic [5:0] OpSrl = 6'b100101;
  localparam logic [5:0] OpSll = 6'b100111;
  localparam logic [5:0] OpLts = 6'b000000;
  localparam logic [5:0] OpLtu = 6'b000001;
  localparam logic [5:0] OpGes = 6'b001010;
  localparam logic [5:0] OpGeu = 6'b001011;
  localparam logic [5:0] OpEq  = 6'b001100;
  localparam logic [5:0] OpNe  = 6'b001101;

  logic w_cmp;
  logic w_is_cmp;

  always_comb begin
    result_o = '0;
    w_cmp    = 1'b0;
    w_is_cmp = 1'b0;
    case (operator_i)
      OpAdd: result_o = operand_a_i + operand_b_i;
      OpSub: result_o = operand_a_i - operand_b_i;
      OpXor: result_o = operand_a_i ^ operand_b_i;
      OpOr:  result_o = operand_a_i | operand_b_i;
      OpAnd: result_o = operand_a_i & operand_b_i;
      OpSra: result_o = $signed(operand_a_i) >>> operand_b_i[4:0];
      OpSrl: result_o = operand_a_i >> operand_b_i[4:0];
      OpSll: result_o = operand_a_i << operand_b_i[4:0];
      OpLts: begin w_is_cmp = 1'b1; w_cmp = $signed(operand_a_i) <  $signed(operand_b_i); end
      OpLtu: begin w_is_cmp = 1'b1; w_cmp = operand_a_i <  operand_b_i; end
      OpGes: begin w_is_cmp = 1'b1; w_cmp = $signed(operand_a_i) >= $signed(operand_b_i); end
      OpGeu: begin w_is_cmp = 1'b1; w_cmp = operand_a_i >= operand_b_i; end
      OpEq:  begin w_is_cmp = 1'b1; w_cmp = operand_a_i == operand_b_i; end
      OpNe:  begin w_is_cmp = 1'b1; w_cmp = operand_a_i != operand_b_i; end
      default: result_o = '0;
    endcase
    // Compare ops return the boolean both as flag and as a 0/1 result (set-less-than style).
    if (w_is_cmp) result_o = {31'b0, w_cmp};
    comparison_result_o = w_cmp;
  end
endmodule

module alu_arbiter #(
  parameter int unsigned RR_INIT = 0
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_a_i,
  input  logic [31:0] req0_b_i,
  input  logic [5:0]  req0_op_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_a_i,
  input  logic [31:0] req1_b_i,
  input  logic [5:0]  req1_op_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_id_o,
  output logic [31:0] rsp_result_o,
  output logic        rsp_flag_o,
  output logic        rsp_err_o
);
  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e      r_state;
  state_e      w_state_nxt;
  logic        r_prio;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [5:0]  r_op;
  logic        r_id;
  logic [31:0] r_result;
  logic        r_flag;
  logic        w_any_valid;
  logic        w_grant_id;
  logic        w_accept;
  logic [31:0] w_alu_result;
  logic        w_alu_flag;

  assign w_any_valid = req0_valid_i | req1_valid_i;
  assign w_grant_id  = (req0_valid_i & req1_valid_i) ? r_prio : req1_valid_i;
  // Gating with rst_n keeps both readies low while reset is held.
  assign w_accept    = (r_state == StIdle) & w_any_valid & rst_n;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_nxt = StExec;
      StExec:  w_state_nxt = StResp;
      StResp:  if (rsp_ready_i) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    req0_ready_o = w_accept & ~w_grant_id;
    req1_ready_o = w_accept & w_grant_id;
    rsp_valid_o  = (r_state == StResp);
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= 1'(RR_INIT);
      r_a    <= '0;
      r_b    <= '0;
      r_op   <= '0;
      r_id   <= 1'b0;
    end else if (w_accept) begin
      r_prio <= ~w_grant_id;
      r_a    <= w_grant_id ? req1_a_i  : req0_a_i;
      r_b    <= w_grant_id ? req1_b_i  : req0_b_i;
      r_op   <= w_grant_id ? req1_op_i : req0_op_i;
      r_id   <= w_grant_id;
    end
  end

  alu_mirisc_v u_alu (
    .operator_i          (r_op),
    .operand_a_i         (r_a),
    .operand_b_i         (r_b),
    .result_o            (w_alu_result),
    .comparison_result_o (w_alu_flag)
  );

`ifdef ALU_ARB_OPCHECK_EN
  logic r_err;
  logic w_op_legal;

  always_comb begin
    unique case (r_op)
      6'b011000, 6'b011001, 6'b101111, 6'b101110, 6'b010101, 6'b100100, 6'b100101,
      6'b100111, 6'b000000, 6'b000001, 6'b001010, 6'b001011, 6'b001100,
      6'b001101: w_op_legal = 1'b1;
      default:   w_op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_flag   <= 1'b0;
      r_err    <= 1'b0;
    end else if (r_state == StExec) begin
      r_result <= w_op_legal ? w_alu_result : '0;
      r_flag   <= w_op_legal & w_alu_flag;
      r_err    <= ~w_op_legal;
    end
  end

  assign rsp_err_o = r_err;
`else
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_flag   <= 1'b0;
    end else if (r_state == StExec) begin
      r_result <= w_alu_result;
      r_flag   <= w_alu_flag;
    end
  end

  assign rsp_err_o = 1'b0;
`endif

  assign rsp_id_o     = r_id;
  assign rsp_result_o = r_result;
  assign rsp_flag_o   = r_flag;
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed scenarios followed by randomized traffic,
// checked against a transaction-level arbitration and ALU model.

module tb_alu_arbiter;
  localparam int unsigned RR_INIT = 0;
  localparam int          Budget  = 40;

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        flag;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v [2];
  logic [31:0] a [2];
  logic [31:0] b [2];
  logic [5:0]  op [2];
  logic        rsp_rdy;
  logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_flag, rsp_err;
  logic [31:0] rsp_result;

  int   checks = 0;
  int   errors = 0;
  int   acc_cnt [2];
  logic to_flag = 1'b0;

  exp_t exp_q[$];
  logic m_busy;
  int   m_age;
  logic m_prio;

  logic pend [2];
  int   snap [2];
  logic [5:0] legal_ops [14] = '{6'b011000, 6'b011001, 6'b101111, 6'b101110, 6'b010101,
                                 6'b100100, 6'b100101, 6'b100111, 6'b000000, 6'b000001,
                                 6'b001010, 6'b001011, 6'b001100, 6'b001101};

  always #5 clk = ~clk;

  alu_arbiter #(.RR_INIT(RR_INIT)) dut (
    .clk_i        (clk),
    .rst_n        (rst_n),
    .req0_valid_i (v[0]),
    .req0_ready_o (req0_ready),
    .req0_a_i     (a[0]),
    .req0_b_i     (b[0]),
    .req0_op_i    (op[0]),
    .req1_valid_i (v[1]),
    .req1_ready_o (req1_ready),
    .req1_a_i     (a[1]),
    .req1_b_i     (b[1]),
    .req1_op_i    (op[1]),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_rdy),
    .rsp_id_o     (rsp_id),
    .rsp_result_o (rsp_result),
    .rsp_flag_o   (rsp_flag),
    .rsp_err_o    (rsp_err)
  );

  function automatic void ref_alu(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic f, output logic e);
    int   sh;
    logic legal;
    sh    = int'(y % 32);
    legal = 1'b1;
    r     = 32'd0;
    f     = 1'b0;
    case (o)
      6'b011000: r = x + y;
      6'b011001: r = x - y;
      6'b101111: r = x ^ y;
      6'b101110: r = x | y;
      6'b010101: r = x & y;
      6'b100100: r = 32'($signed(x) >>> sh);
      6'b100101: r = x >> sh;
      6'b100111: r = x << sh;
      6'b000000: f = $signed(x) < $signed(y);
      6'b000001: f = x < y;
      6'b001010: f = $signed(x) >= $signed(y);
      6'b001011: f = x >= y;
      6'b001100: f = x == y;
      6'b001101: f = x != y;
      default:   legal = 1'b0;
    endcase
    if (o inside {6'b000000, 6'b000001, 6'b001010, 6'b001011, 6'b001100, 6'b001101})
      r = {31'b0, f};
`ifdef ALU_ARB_OPCHECK_EN
    e = !legal;
`else
    e = 1'b0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Monitor: cycle-level view of the protocol, sampled mid-cycle.
  initial begin
    exp_t        e;
    logic        gid, e_acc, e_rv;
    logic [31:0] r;
    logic        f, er;
    acc_cnt[0] = 0;
    acc_cnt[1] = 0;
    m_busy = 1'b0;
    m_age  = 0;
    m_prio = 1'(RR_INIT);
    forever begin
      @(negedge clk);
      chk("accept_timeout", 32'(to_flag), 32'd0);
      if (!rst_n) begin
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_result", rsp_result, 32'd0);
        chk("rst_flag", 32'(rsp_flag), 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        m_busy = 1'b0;
        m_age  = 0;
        m_prio = 1'(RR_INIT);
        exp_q.delete();
      end else begin
        e_rv  = m_busy && (m_age >= 2);
        gid   = (v[0] && v[1]) ? m_prio : v[1];
        e_acc = !m_busy && (v[0] || v[1]);
        chk("ready0", 32'(req0_ready), 32'(e_acc && !gid));
        chk("ready1", 32'(req1_ready), 32'(e_acc && gid));
        chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
        if (e_rv) begin
          if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
          end else begin
            e = exp_q[0];
            chk("rsp_id", 32'(rsp_id), 32'(e.id));
            chk("rsp_result", rsp_result, e.res);
            chk("rsp_flag", 32'(rsp_flag), 32'(e.flag));
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
            if (rsp_rdy) void'(exp_q.pop_front());
          end
        end
        if (e_acc) begin
          ref_alu(op[gid], a[gid], b[gid], r, f, er);
          e.id = gid; e.res = r; e.flag = f; e.err = er;
          exp_q.push_back(e);
          acc_cnt[gid] = acc_cnt[gid] + 1;
          m_prio = !gid;
          m_busy = 1'b1;
          m_age  = 1;
        end else if (m_busy) begin
          if (m_age >= 2 && rsp_rdy) m_busy = 1'b0;
          else m_age++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int n = 0; n < 2; n++) begin
      if (pend[n] && acc_cnt[n] != snap[n]) begin
        pend[n] = 1'b0;
        v[n]    = 1'b0;
        // Scramble inputs after accept; the response must not follow them.
        a[n] = $urandom; b[n] = $urandom; op[n] = 6'($urandom);
      end
    end
  endtask

  task automatic start(input int n, input logic [5:0] o, input logic [31:0] x, input logic [31:0] y);
    v[n] = 1'b1; op[n] = o; a[n] = x; b[n] = y;
    pend[n] = 1'b1;
    snap[n] = acc_cnt[n];
  endtask

  task automatic drain();
    int waited = 0;
    while ((pend[0] || pend[1]) && waited < Budget) begin
      tick();
      waited++;
    end
    if (pend[0] || pend[1]) begin
      to_flag = 1'b1;
      v[0] = 1'b0; v[1] = 1'b0; pend[0] = 1'b0; pend[1] = 1'b0;
      tick();
      to_flag = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int n = 0; n < 2; n++) begin
      v[n] = 1'b0; a[n] = '0; b[n] = '0; op[n] = '0; pend[n] = 1'b0; snap[n] = 0;
    end
    rsp_rdy = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    // Lone ADD accepted on the first edge after reset release.
    start(0, 6'b011000, 32'd5, 32'd7);
    drain();
    repeat (4) tick();

    // Both valid straight after reset: req0 first, then req1.
    pulse_reset();
    start(0, 6'b011001, 32'd10, 32'd3);
    start(1, 6'b000001, 32'd1, 32'd2);
    drain();
    repeat (4) tick();

    // Consumer stalls in RESP while req1 waits.
    rsp_rdy = 1'b0;
    start(0, 6'b011000, 32'd100, 32'd23);
    drain();
    start(1, 6'b101111, 32'hF0F0_1234, 32'h0FF0_4321);
    repeat (6) tick();
    rsp_rdy = 1'b1;
    drain();
    repeat (4) tick();

    // Illegal op code.
    start(0, 6'b111111, 32'd1, 32'd1);
    drain();
    repeat (4) tick();

    // Reset during EXEC discards the op and restores priority.
    start(1, 6'b011000, 32'd1, 32'd1);
    drain();
    repeat (4) tick();
    start(0, 6'b001100, 32'd4, 32'd4);
    drain();
    pulse_reset();
    start(0, 6'b100100, 32'h8000_0010, 32'd4);
    start(1, 6'b100111, 32'h0000_0003, 32'd31);
    drain();
    repeat (4) tick();

    // Random traffic with withdrawals and back-pressure.
    for (int i = 0; i < 3000; i++) begin
      tick();
      rsp_rdy = ($urandom_range(0, 3) != 0);
      for (int n = 0; n < 2; n++) begin
        if (!pend[n] && $urandom_range(0, 2) == 0) begin
          start(n, ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 13)],
                ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom,
                ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom);
        end else if (pend[n] && $urandom_range(0, 9) == 0) begin
          v[n] = 1'b0;
          pend[n] = 1'b0;
        end
      end
    end
    v[0] = 1'b0; v[1] = 1'b0; pend[0] = 1'b0; pend[1] = 1'b0;
    rsp_rdy = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter RR_INIT, default 0: requester that holds priority after reset (0 or 1).
REQ-002 Port clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 Port rst_n  in  1  reset; asynchronous assertion, active-low.
REQ-004 Port reqN_valid_i (N=0,1)  in  1  requester N presents an operation.
REQ-005 Port reqN_ready_o (N=0,1)  out  1  requester N operation accepted this cycle.
REQ-006 Port reqN_a_i / reqN_b_i (N=0,1)  in  32 each  operand A / operand B.
REQ-007 Port reqN_op_i (N=0,1)  in  6  ALU operation code, same encoding as alu_mirisc_v.
REQ-008 Port rsp_valid_o  out  1  response available.
REQ-009 Port rsp_ready_i  in  1  consumer takes response.
REQ-010 Port rsp_id_o  out  1  index of requester that owns the response.
REQ-011 Port rsp_result_o  out  32  ALU result.
REQ-012 Port rsp_flag_o  out  1  ALU flag.
REQ-013 Port rsp_err_o  out  1  operation code was illegal.

Function
REQ-014 Block SHALL instantiate exactly one alu_mirisc_v, shared by both requesters, fed only from internal operand/op registers.
REQ-015 FSM SHALL have states IDLE, EXEC, RESP; IDLE->EXEC on accept, EXEC->RESP unconditionally, RESP->IDLE when rsp_valid_o & rsp_ready_i.
REQ-016 In IDLE, reqN_ready_o SHALL be combinationally 1 only for the granted requester with reqN_valid_i=1; both 0 in EXEC and RESP.
REQ-017 Grant: single requester valid -> that requester; both valid -> requester holding priority; priority SHALL move to the other requester after each accept.
REQ-018 On accept (cycle T) block SHALL latch a, b, op and requester id; inputs after T SHALL not affect the response.
REQ-019 At end of EXEC (cycle T+1) ALU result and flag SHALL be registered; rsp_valid_o SHALL rise at T+2.
REQ-020 rsp_id_o, rsp_result_o, rsp_flag_o, rsp_err_o SHALL be stable while rsp_valid_o=1 and rsp_ready_i=0.
REQ-021 No new accept SHALL occur in the RESP-exit cycle; next accept is earliest the cycle after return to IDLE (max throughput 1 op / 3 cycles).
REQ-022 Legal op codes: ADD 011000, SUB 011001, XOR 101111, OR 101110, AND 010101, SRA 100100, SRL 100101, SLL 100111, LTS 000000, LTU 000001, GES 001010, GEU 001011, EQ 001100, NE 001101.
REQ-023 reqN_valid_i dropping without accept SHALL leave state and priority unchanged.

Reset
REQ-024 On rst_n=0 FSM SHALL go to IDLE immediately, including mid-EXEC or mid-RESP, discarding the in-flight operation.
REQ-025 Reset values: rsp_valid_o=0, rsp_id_o=0, rsp_result_o=0, rsp_flag_o=0, rsp_err_o=0, reqN_ready_o=0, priority=RR_INIT.
REQ-026 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-027 Macro ALU_ARB_OPCHECK_EN defined: op not in REQ-022 list SHALL give rsp_err_o=1, rsp_result_o=0, rsp_flag_o=0, same latency.
REQ-028 Macro ALU_ARB_OPCHECK_EN undefined: op passed unchecked, rsp_result_o/rsp_flag_o straight from ALU, rsp_err_o tied 0.

Verification
REQ-029 req0 ADD a=5 b=7 alone, rsp_ready_i=1 -> accept at T, rsp_valid_o at T+2, result=12, id=0, err=0.
REQ-030 Both valid from reset (RR_INIT=0), req0 SUB 10-3, req1 LTU 1<2 -> responses in order id0 result=7, then id1 result=1 flag=1.
REQ-031 rsp_ready_i=0 for 5 cycles during RESP, req1 valid -> response held stable, reqN_ready_o=0 throughout, req1 accepted after handshake.
REQ-032 OPCHECK_EN defined, op=111111 a=1 b=1 -> err=1, result=0, flag=0; undefined -> err=0.
REQ-033 rst_n pulsed low in EXEC of req0 EQ 4==4 -> rsp_valid_o=0 immediately, no response ever issued for it, priority back to RR_INIT.
